// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared constants and the fetch-to-decode entry type for the RV32I pipeline
package rv_pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } if_id_entry;
endpackage

// File: rtl/if_inst_fifo.sv
// if_inst_fifo: DEPTH-entry synchronous instruction buffer with flush and occupancy count
module if_inst_fifo
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  if_id_entry               wdata,
  output if_id_entry               rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  if_id_entry r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop, w_full;
  assign empty  = r_cnt == '0;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rd];
  assign w_push = push && !flush;
  assign w_pop  = pop && !flush && !empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= wdata;
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && !flush && w_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && !flush && empty));
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32I fetch stage owning the PC, imem requests, redirect handling and the decode handshake
module if_fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misalign
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] r_pc;
  logic            r_inflight, r_kill, r_mis_pend, r_mis_done;
  logic            w_redir, w_empty, w_push, w_pop, w_rsp, w_mpush;
  logic [XLEN-1:0] w_target;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  if_id_entry      w_wdata, w_head;
  assign w_redir   = redirect_valid || trap_valid;
  assign w_target  = trap_valid ? trap_pc : redirect_pc;
  // occupancy uses the registered count only, so id_ready never reaches imem_req
  assign w_occ     = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign imem_req  = !rst && !w_redir && !r_mis_pend && (w_occ < (CW+1)'(DEPTH));
  assign imem_addr = r_pc;
  assign w_rsp     = r_inflight && !r_kill && !w_redir;
  assign w_mpush   = r_mis_pend && !r_mis_done && w_empty && !w_redir;
  assign w_push    = w_rsp || w_mpush;
  // the in-flight word belongs to the address just before the advanced PC
  assign w_wdata   = w_mpush ? if_id_entry'{inst: INST_NOP, pc: r_pc, misalign: 1'b1}
                             : if_id_entry'{inst: imem_rdata, pc: r_pc - 32'd4, misalign: 1'b0};
  assign id_valid    = !w_empty && !w_redir;
  assign w_pop       = id_valid && id_ready;
  assign id_inst     = w_empty ? INST_NOP : w_head.inst;
  assign id_pc       = w_empty ? '0 : w_head.pc;
  assign id_misalign = !w_empty && w_head.misalign;
  if_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_redir),
    .wdata (w_wdata),
    .rdata (w_head),
    .empty (w_empty),
    .count (w_count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_mis_pend <= 1'b0;
      r_mis_done <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      r_kill     <= w_redir && r_inflight;
      r_pc       <= w_redir ? w_target : imem_req ? r_pc + 32'd4 : r_pc;
      r_mis_pend <= w_redir ? |w_target[1:0] : r_mis_pend;
      r_mis_done <= w_redir ? 1'b0 : r_mis_done || w_mpush;
    end
  a_req_aligned: assert property (@(posedge clk) disable iff (rst) imem_req |-> imem_addr[1:0] == 2'b00);
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenario tasks plus a queue-based reference model under random stimulus
module tb_if_fetch_stage;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, id_valid, id_misalign;
  logic [31:0] imem_addr, imem_rdata, id_inst, id_pc;
  logic        redirect_valid = 1'b0, trap_valid = 1'b0, id_ready = 1'b1;
  logic [31:0] redirect_pc = '0, trap_pc = '0;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_a = '0;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed { logic [31:0] inst; logic [31:0] pc; logic mis; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_rpc;
  logic        m_inf, m_mp, m_md;

  if_fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_misalign(id_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  always @(posedge clk) begin
    rsp_v <= imem_req;
    rsp_a <= imem_addr;
  end
  assign imem_rdata = rsp_v ? mem(rsp_a) : 32'hBAD0_0000 ^ rsp_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    trap_valid = 1'b0;
    id_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_inst !== NOP) begin n_bad++; $display("FAIL reset_inst got %h exp %h", id_inst, NOP); end
    n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h exp 0", id_pc); end
    n_cmp++; if (id_misalign !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %b exp 0", id_misalign); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] na, nd;
    int first;
    do_reset();
    na = 0; nd = 0; first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL stream_first_req got %b exp 1", imem_req); end
      end
      if (imem_req) begin
        n_cmp++; if (imem_addr !== na) begin n_bad++; $display("FAIL stream_addr got %h exp %h", imem_addr, na); end
        na += 4;
      end
      if (k < 2) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid cyc %0d got %b exp 0", k, id_valid); end
      end
      if (id_valid) begin
        if (first < 0) first = k;
        n_cmp++; if (id_pc !== nd) begin n_bad++; $display("FAIL stream_pc got %h exp %h", id_pc, nd); end
        n_cmp++; if (id_inst !== mem(nd)) begin n_bad++; $display("FAIL stream_inst got %h exp %h", id_inst, mem(nd)); end
        nd += 4;
      end
      tick();
    end
    n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL stream_first_valid_cycle got %0d exp 2", first); end
    n_cmp++; if (nd < 32'd16) begin n_bad++; $display("FAIL stream_delivered got %h exp >=10", nd); end
  endtask

  task automatic test_stall();
    logic [31:0] na, nd;
    int last;
    do_reset();
    na = 0; nd = 0; last = -1;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) id_ready = 1'b0;
      if (k == 9) id_ready = 1'b1;
      @(negedge clk);
      if (imem_req) begin
        n_cmp++; if (imem_addr !== na) begin n_bad++; $display("FAIL stall_addr got %h exp %h", imem_addr, na); end
        na += 4;
      end
      if (k >= 6 && k <= 8) begin
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin n_bad++; $display("FAIL stall_hold cyc %0d got v=%b pc=%h exp v=1 pc=8", k, id_valid, id_pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req cyc %0d got %b exp 0", k, imem_req); end
      end
      if (id_valid && id_ready) begin
        n_cmp++; if (id_pc !== nd) begin n_bad++; $display("FAIL stall_order got %h exp %h", id_pc, nd); end
        if (k >= 10) begin
          n_cmp++; if (k - last > 2) begin n_bad++; $display("FAIL stall_gap got %0d exp <=2", k - last); end
        end
        nd += 4;
        last = k;
      end
      tick();
    end
    n_cmp++; if (nd < 32'h18) begin n_bad++; $display("FAIL stall_delivered got %h exp >=18", nd); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid got %b exp 0", id_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_req got %b exp 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL redir_target got req=%b addr=%h exp 1/100", imem_req, imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush got %b exp 0", id_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL redir_dropped got %b exp 0", id_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_bad++; $display("FAIL redir_first got v=%b pc=%h exp 1/100", id_valid, id_pc); end
    n_cmp++; if (id_inst !== mem(32'h100)) begin n_bad++; $display("FAIL redir_inst got %h exp %h", id_inst, mem(32'h100)); end
    tick();
  endtask

  task automatic test_trap_priority();
    trap_valid = 1'b1; trap_pc = 32'h80;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL trap_valid got %b exp 0", id_valid); end
    tick();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_bad++; $display("FAIL trap_target got req=%b addr=%h exp 1/80", imem_req, imem_addr); end
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h80) begin n_bad++; $display("FAIL trap_first got v=%b pc=%h exp 1/80", id_valid, id_pc); end
    tick();
  endtask

  task automatic test_misalign();
    bit found;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mis_req cyc %0d got %b exp 0", i, imem_req); end
      if (found) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL mis_idle got %b exp 0", id_valid); end
      end else if (id_valid) begin
        found = 1'b1;
        n_cmp++; if (id_pc !== 32'h102) begin n_bad++; $display("FAIL mis_pc got %h exp 102", id_pc); end
        n_cmp++; if (id_inst !== NOP) begin n_bad++; $display("FAIL mis_inst got %h exp %h", id_inst, NOP); end
        n_cmp++; if (id_misalign !== 1'b1) begin n_bad++; $display("FAIL mis_flag got %b exp 1", id_misalign); end
      end
      tick();
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mis_entry_seen got %b exp 1", found); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_bad++; $display("FAIL mis_recover got req=%b addr=%h exp 1/40", imem_req, imem_addr); end
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_misalign !== 1'b0) begin n_bad++; $display("FAIL mis_recover_out got v=%b pc=%h m=%b exp 1/40/0", id_valid, id_pc, id_misalign); end
    tick();
  endtask

  task automatic test_wrap_reset();
    logic [31:0] nd;
    bit got;
    int dl;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first got req=%b addr=%h exp 1/fffffffc", imem_req, imem_addr); end
    tick();
    nd = 32'hFFFF_FFFC; got = 1'b0; dl = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (imem_req && !got) begin
        got = 1'b1;
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
      end
      if (id_valid) begin
        n_cmp++; if (id_pc !== nd) begin n_bad++; $display("FAIL wrap_pc got %h exp %h", id_pc, nd); end
        nd += 4;
        dl++;
      end
      tick();
    end
    n_cmp++; if (got !== 1'b1 || dl < 2) begin n_bad++; $display("FAIL wrap_progress got req=%b delivered=%0d exp 1/>=2", got, dl); end
    id_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_stalled got %b exp 1", id_valid); end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_out got v=%b req=%b exp 0/0", id_valid, imem_req); end
    n_cmp++; if (imem_addr !== 32'h0 || id_pc !== 32'h0) begin n_bad++; $display("FAIL midrst_pc got addr=%h pc=%h exp 0/0", imem_addr, id_pc); end
    tick();
    rst = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_restart got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_bad++; $display("FAIL midrst_first got v=%b pc=%h exp 1/0", id_valid, id_pc); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    logic rdr, e_req, e_valid, mp;
    ent_t h;
    int r;
    do_reset();
    mq.delete(); m_pc = 0; m_rpc = 0; m_inf = 0; m_mp = 0; m_md = 0;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      rst = ($urandom_range(0, 149) == 0);
      redirect_valid = r < 6;
      trap_valid = r >= 4 && r < 8;
      redirect_pc = rnd_tgt();
      trap_pc = rnd_tgt();
      id_ready = $urandom_range(0, 3) != 0;
      if (rst) begin
        mq.delete(); m_pc = 0; m_inf = 0; m_mp = 0; m_md = 0;
      end
      rdr = !rst && (redirect_valid || trap_valid);
      tgt = trap_valid ? trap_pc : redirect_pc;
      e_valid = !rst && !rdr && mq.size() > 0;
      e_req = !rst && !rdr && !m_mp && (mq.size() + int'(m_inf) < DEPTH);
      @(negedge clk);
      n_cmp++; if (imem_req !== e_req) begin n_bad++; $display("FAIL rnd_req cyc %0d got %b exp %b", c, imem_req, e_req); end
      n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, imem_addr, m_pc); end
      n_cmp++; if (id_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, id_valid, e_valid); end
      if (e_valid) begin
        h = mq[0];
        n_cmp++; if (id_pc !== h.pc || id_inst !== h.inst || id_misalign !== h.mis) begin n_bad++; $display("FAIL rnd_head cyc %0d got %h/%h/%b exp %h/%h/%b", c, id_pc, id_inst, id_misalign, h.pc, h.inst, h.mis); end
      end
      if (rdr) begin
        mq.delete(); m_mp = tgt[1:0] != 2'b00; m_md = 0; m_pc = tgt; m_inf = 0;
      end else if (!rst) begin
        mp = m_mp && !m_md && mq.size() == 0;
        if (e_valid && id_ready) void'(mq.pop_front());
        if (m_inf) mq.push_back('{inst: mem(m_rpc), pc: m_rpc, mis: 1'b0});
        if (mp) begin mq.push_back('{inst: NOP, pc: m_pc, mis: 1'b1}); m_md = 1; end
        if (e_req) begin m_rpc = m_pc; m_pc += 4; end
        m_inf = e_req;
      end
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_trap_priority();
    test_misalign();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage for the pipelined RV32I core. It sits directly upstream of the decode/control stage, whose Op/Funct7/Funct3 fields come from id_inst.
It owns the PC, issues requests to a 1-cycle-latency synchronous instruction memory and buffers returned words in a small FIFO. It presents instructions to decode over a valid/ready handshake.
It takes redirects from EX (branch/jal/jalr) and from the trap unit (illegal instruction, CSR trap vector).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request this cycle
imem_addr  out  32  word-aligned fetch address
imem_rdata  in  32  instruction word, valid exactly one cycle after an imem_req cycle
redirect_valid  in  1  EX resolved taken branch/jal/jalr
redirect_pc  in  32  EX target address
trap_valid  in  1  trap/exception redirect
trap_pc  in  32  trap vector address
id_ready  in  1  decode can accept (deasserted by hazard stall)
id_valid  out  1  id_inst/id_pc valid
id_inst  out  32  instruction to decode
id_pc  out  32  PC of id_inst
id_misalign  out  1  fetch-address-misaligned exception flag for id_pc

Behaviour:
- Reset (async, rst=1):
  - pc_q=RESET_PC.
  - FIFO empty; inflight=0; kill=0.
  - Outputs: imem_req=0, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0, id_misalign=0, imem_addr=RESET_PC.
- Reset released mid-transaction: no in-flight response is captured.
- Request rule:
  - imem_req = !rst && !redirect_valid && !trap_valid && (fifo_count + inflight < DEPTH) && !misalign_pending.
  - imem_addr=pc_q.
  - On a request cycle: pc_q <= pc_q+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); inflight<=1.
- Response:
  - In the cycle after a request, imem_rdata and its PC are written to the FIFO tail unless kill=1.
  - If kill=1 the response is dropped.
- Latency: request in cycle N -> FIFO write at end of N+1 -> id_valid high in N+2.
- Output: id_valid/id_inst/id_pc come from the FIFO head combinationally; pop when id_valid && id_ready.
- Stall (id_ready=0): head is held stable; fetching continues until FIFO plus in-flight reach DEPTH. No word is lost or duplicated.
- Redirect:
  - Target = trap_pc if trap_valid, else redirect_pc. Trap has priority.
  - In that cycle:
    - id_valid is forced 0 and any pop is suppressed.
    - FIFO is flushed at the edge.
    - kill<=inflight, so the response of the prior cycle's request is discarded.
    - pc_q<=target.
  - Next cycle: request with the target; id_valid no earlier than redirect cycle+3.
- Misaligned target (target[1:0]!=0):
  - No imem request for it; misalign_pending set.
  - Once the FIFO is empty, push one entry: inst=NOP, pc=target, misalign=1.
  - Stage then idles (imem_req=0) until the next redirect/trap clears misalign_pending.
- Simultaneous push and pop: both occur; count unchanged.
- Redirect in the same cycle as a response arrival: the response is dropped.
- FIFO full plus pop: a new request may issue the same cycle only if count+inflight-pop < DEPTH. The rule uses registered count, so no combinational id_ready->imem_req path; one bubble is acceptable.
- Assertions: FIFO never overflows or underflows; imem_addr[1:0]==0 whenever imem_req.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - INST_NOP = 32'h0000_0013
  - default RESET_PC
  - XLEN=32
  - if_id_entry struct {inst[31:0], pc[31:0], misalign}
- One sub-module: if_inst_fifo, a DEPTH-entry synchronous FIFO with push, pop, flush, count, async active-high reset.
- PC/request/kill logic stays in if_fetch_stage.

Test Plan:
- Reset release, id_ready=1, imem returns addr-indexed words:
  - imem_addr 0,4,8,... on consecutive cycles.
  - First id_valid at cycle 2 with id_pc=0.
  - Then one instruction per cycle in order.
- id_ready=0 for 5 cycles from cycle 4:
  - id_pc holds 8; imem_req drops after 2 outstanding.
  - On release, pcs 8,C,10,14 are delivered with no gap beyond one bubble, no duplicates.
- redirect_valid with redirect_pc=0x100 while a response is in flight:
  - Old response dropped; FIFO flushed.
  - Next imem_addr=0x100; next id_pc=0x100 exactly 3 cycles after the redirect.
- trap_valid (trap_pc=0x80) and redirect_valid (0x200) in the same cycle: next imem_addr=0x80.
- redirect_pc=0x102:
  - No imem_req.
  - id_valid with id_pc=0x102, id_inst=0x00000013, id_misalign=1.
  - Stage idles until redirect to 0x40, then fetches 0x40.
- pc_q=0xFFFF_FFFC sequence:
  - Next imem_addr=0x0.
  - Asserting rst mid-stall clears id_valid immediately and restarts at RESET_PC.
